iob_soc_sut_rst_seq: RTL and testbench

Board-level reset/bring-up sequencer that sits directly upstream of the system core's reset input in the FPGA wrapper.
- Pulses the Ethernet PHY and DDR3 controller resets, waits for PLL lock and memory init/calibration, then holds before releasing system reset.
- Handles timeouts and calibration failure with bounded retries.
- Replaces the ad-hoc OR of resetn/locked/init_done with a deterministic, observable sequence.

---
 rtl/iob_soc_sut_rst_seq_pkg.sv | 19 +
 rtl/iob_soc_sut_rst_seq.sv | 91 +++++++++
 tb/tb_iob_soc_sut_rst_seq.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/iob_soc_sut_rst_seq_pkg.sv
// iob_soc_sut_rst_seq_pkg: state encoding and counter sizing for the board reset sequencer
package iob_soc_sut_rst_seq_pkg;
  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_PHY_RST   = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_WAIT_INIT = 3'd3,
    ST_HOLD      = 3'd4,
    ST_RUN       = 3'd5,
    ST_FAIL      = 3'd6
  } state_t;
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    m = m > d ? m : d;
    return $clog2(m) + 1;
  endfunction
endpackage

// File: rtl/iob_soc_sut_rst_seq.sv
// iob_soc_sut_rst_seq: pulses PHY/DDR resets, waits for PLL lock and DDR init, holds, then releases sys_rst_o; bounded retries, sticky fail_o
module iob_soc_sut_rst_seq
  import iob_soc_sut_rst_seq_pkg::*;
#(
  parameter int PHY_RST_CYCLES = 1000,
  parameter int LOCK_TIMEOUT   = 1000000,
  parameter int INIT_TIMEOUT   = 4000000,
  parameter int HOLD_CYCLES    = 16,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pll_locked_i,
  input  logic       init_done_i,
  input  logic       cal_fail_i,
  output logic       phy_resetn_o,
  output logic       mem_resetn_o,
  output logic       sys_rst_o,
  output logic       fail_o,
  output logic [2:0] retry_cnt_o,
  output logic [2:0] state_o
);
  localparam int CW = cnt_width(PHY_RST_CYCLES, LOCK_TIMEOUT, INIT_TIMEOUT, HOLD_CYCLES);
  localparam logic [CW-1:0] PHY_LAST  = CW'(PHY_RST_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] INIT_LAST = CW'(INIT_TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [2:0]    RC_MAX    = 3'(MAX_RETRIES);
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0] rc, rc_d;
  logic retry, up_d;
  always_comb begin
    state_d = state;
    cnt_d = cnt + 1'b1;
    retry = 1'b0;
    case (state)
      ST_RESET: begin
        state_d = ST_PHY_RST;
        cnt_d = '0;
      end
      ST_PHY_RST: if (cnt == PHY_LAST) begin
        state_d = ST_WAIT_LOCK;
        cnt_d = '0;
      end
      ST_WAIT_LOCK: if (pll_locked_i) begin
        state_d = ST_WAIT_INIT;
        cnt_d = '0;
      end else retry = LOCK_TIMEOUT != 0 && cnt == LOCK_LAST;
      ST_WAIT_INIT: if (cal_fail_i || !pll_locked_i) retry = 1'b1;
      else if (init_done_i) begin
        state_d = ST_HOLD;
        cnt_d = '0;
      end else retry = INIT_TIMEOUT != 0 && cnt == INIT_LAST;
      ST_HOLD: if (!pll_locked_i || !init_done_i) retry = 1'b1;
      else if (cnt == HOLD_LAST) state_d = ST_RUN;
      ST_RUN: retry = !pll_locked_i || !init_done_i || cal_fail_i;
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_RESET;
    endcase
    // retry budget exhausted parks in FAIL; rc never wraps
    rc_d = retry && rc != RC_MAX ? rc + 3'd1 : rc;
    if (retry) begin
      state_d = rc == RC_MAX ? ST_FAIL : ST_PHY_RST;
      cnt_d = '0;
    end
    up_d = state_d inside {ST_WAIT_LOCK, ST_WAIT_INIT, ST_HOLD, ST_RUN};
  end
  // outputs are decoded from the next state so they change on the same edge as the state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_RESET;
      cnt <= '0;
      rc <= '0;
      sys_rst_o <= 1'b1;
      phy_resetn_o <= 1'b0;
      mem_resetn_o <= 1'b0;
      fail_o <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      rc <= rc_d;
      sys_rst_o <= state_d != ST_RUN;
      phy_resetn_o <= up_d;
      mem_resetn_o <= up_d;
      fail_o <= state_d == ST_FAIL;
    end
  end
  assign state_o = state;
  assign retry_cnt_o = rc;
endmodule

// File: tb/tb_iob_soc_sut_rst_seq.sv
// tb_iob_soc_sut_rst_seq: scoreboard bench; stimulus queues expected output changes with their edge number, monitor pops on every change
module tb_iob_soc_sut_rst_seq;
  logic clk = 1'b0, rst = 1'b1, rst2 = 1'b1, pll = 1'b1, init = 1'b1, cal = 1'b0;
  logic phy0, mem0, sys0, fail0, phy1, mem1, sys1, fail1;
  logic [2:0] rc0, st0, rc1, st1;
  typedef struct packed {logic [2:0] st; logic [2:0] rc; logic fail, sys, mem, phy;} obs_t;
  typedef struct packed {int cyc; obs_t o;} exp_t;
  exp_t q0[$], q1[$];
  obs_t obs0, obs1;
  obs_t prev [2];
  logic [1:0] first = 2'b11;
  logic en = 1'b0;
  int cyc = 0, compared = 0, mism = 0;
  iob_soc_sut_rst_seq #(.PHY_RST_CYCLES(4), .LOCK_TIMEOUT(8), .INIT_TIMEOUT(20), .HOLD_CYCLES(2), .MAX_RETRIES(2)) dut (
    .clk_i(clk), .rst_i(rst), .pll_locked_i(pll), .init_done_i(init), .cal_fail_i(cal),
    .phy_resetn_o(phy0), .mem_resetn_o(mem0), .sys_rst_o(sys0), .fail_o(fail0), .retry_cnt_o(rc0), .state_o(st0));
  iob_soc_sut_rst_seq #(.PHY_RST_CYCLES(4), .LOCK_TIMEOUT(0), .INIT_TIMEOUT(20), .HOLD_CYCLES(2), .MAX_RETRIES(2)) dut_nt (
    .clk_i(clk), .rst_i(rst2), .pll_locked_i(pll), .init_done_i(init), .cal_fail_i(cal),
    .phy_resetn_o(phy1), .mem_resetn_o(mem1), .sys_rst_o(sys1), .fail_o(fail1), .retry_cnt_o(rc1), .state_o(st1));
  assign obs0 = {st0, rc0, fail0, sys0, mem0, phy0};
  assign obs1 = {st1, rc1, fail1, sys1, mem1, phy1};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic obs_t mk(input int st, input int rc);
    obs_t o;
    o.st = 3'(st);
    o.rc = 3'(rc);
    o.fail = st == 6;
    o.sys = st != 5;
    o.mem = st >= 2 && st <= 5;
    o.phy = o.mem;
    return o;
  endfunction
  task automatic push(input int id, input int at, input int st, input int rc);
    exp_t e;
    e.cyc = at;
    e.o = mk(st, rc);
    if (id == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask
  task automatic pop(input int id);
    if (id == 0) void'(q0.pop_front());
    else void'(q1.pop_front());
  endtask
  task automatic mon(input int id, input obs_t cur);
    exp_t e;
    logic has;
    has = id == 0 ? q0.size() > 0 : q1.size() > 0;
    e = '0;
    if (has) e = id == 0 ? q0[0] : q1[0];
    if (first[id] || cur !== prev[id]) begin
      compared++;
      if (!has) begin
        mism++;
        $display("FAIL dut%0d unexpected change at edge %0d: got %b (st|rc|fail|sys|mem|phy)", id, cyc, cur);
      end else begin
        pop(id);
        if (cur !== e.o || (e.cyc >= 0 && e.cyc != cyc)) begin
          mism++;
          $display("FAIL dut%0d change at edge %0d: got %b, want %b at edge %0d (st|rc|fail|sys|mem|phy)", id, cyc, cur, e.o, e.cyc);
        end
      end
    end else if (has && e.cyc >= 0 && cyc > e.cyc) begin
      compared++;
      mism++;
      $display("FAIL dut%0d missed change: still %b at edge %0d, want %b at edge %0d", id, cur, cyc, e.o, e.cyc);
      pop(id);
    end
    first[id] = 1'b0;
    prev[id] = cur;
  endtask
  always @(negedge clk) if (en) begin
    mon(0, obs0);
    mon(1, obs1);
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    int c;
    tick(3);
    push(0, -1, 0, 0);
    push(1, -1, 0, 0);
    en = 1'b1;
    // bring-up with all inputs good: resetn at +5, sys_rst_o low at +9
    c = cyc;
    rst = 1'b0;
    push(0, c + 1, 1, 0); push(0, c + 5, 2, 0); push(0, c + 6, 3, 0); push(0, c + 7, 4, 0); push(0, c + 9, 5, 0);
    tick(12);
    // one-cycle drop of init_done in RUN restarts the whole sequence
    c = cyc;
    init = 1'b0;
    push(0, c + 1, 1, 1); push(0, c + 5, 2, 1); push(0, c + 6, 3, 1); push(0, c + 7, 4, 1); push(0, c + 9, 5, 1);
    tick(1);
    init = 1'b1;
    tick(10);
    // reset in RUN, then cal_fail together with init_done, then reset pulse in HOLD with rc=1
    c = cyc;
    rst = 1'b1;
    init = 1'b0;
    push(0, c + 1, 0, 0); push(0, c + 2, 1, 0); push(0, c + 6, 2, 0); push(0, c + 7, 3, 0);
    push(0, c + 10, 1, 1); push(0, c + 14, 2, 1); push(0, c + 15, 3, 1); push(0, c + 16, 4, 1);
    push(0, c + 17, 0, 0); push(0, c + 18, 1, 0); push(0, c + 22, 2, 0); push(0, c + 23, 3, 0);
    push(0, c + 24, 4, 0); push(0, c + 26, 5, 0);
    tick(1);
    rst = 1'b0;
    tick(8);
    init = 1'b1;
    cal = 1'b1;
    tick(1);
    cal = 1'b0;
    tick(6);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(11);
    // no lock: two timed-out retries, then FAIL which only rst_i clears
    c = cyc;
    rst = 1'b1;
    pll = 1'b0;
    push(0, c + 1, 0, 0); push(0, c + 2, 1, 0); push(0, c + 6, 2, 0);
    push(0, c + 14, 1, 1); push(0, c + 18, 2, 1); push(0, c + 26, 1, 2); push(0, c + 30, 2, 2);
    push(0, c + 38, 6, 2); push(0, c + 71, 0, 0);
    tick(1);
    rst = 1'b0;
    tick(59);
    pll = 1'b1;
    tick(10);
    rst = 1'b1;
    tick(2);
    // no lock timeout: waits indefinitely, then completes once locked
    c = cyc;
    rst2 = 1'b0;
    pll = 1'b0;
    push(1, c + 1, 1, 0); push(1, c + 5, 2, 0);
    push(1, c + 10006, 3, 0); push(1, c + 10007, 4, 0); push(1, c + 10009, 5, 0);
    tick(10005);
    pll = 1'b1;
    tick(15);
    en = 1'b0;
    compared++;
    if (q0.size() != 0) begin
      mism++;
      $display("FAIL dut0 pending: %0d expected changes never seen, want 0", q0.size());
    end
    compared++;
    if (q1.size() != 0) begin
      mism++;
      $display("FAIL dut1 pending: %0d expected changes never seen, want 0", q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
